serial_word_receiver: RTL

//   Serial-to-parallel receiver for LSB-first bit streams from the parallel-to-serial shifter stage.

---
 rtl/serial_word_receiver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_word_receiver.sv
// LSB-first serial-to-parallel receiver with a one-entry valid/ready output buffer and sticky overrun.
// Define PARITY_EN to append an even-parity bit to each frame and expose out_perr.
module serial_word_receiver #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sin_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovr,
  input  logic             ovr_clr
`ifdef PARITY_EN
  ,
  output logic             out_perr
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, state_n;
  logic [CW-1:0]    bit_cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             load;
  logic             overrun;
`ifdef PARITY_EN
  logic             perr_w;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = bit_cnt;
    shreg_n  = shreg;
    complete = 1'b0;
    word     = {sin, shreg[WIDTH-1:1]};
`ifdef PARITY_EN
    perr_w   = 1'b0;
`endif
    // A start strobe always begins a fresh frame, aborting any partial one.
    if (sin_en && sin_start) begin
      shreg_n = {sin, {(WIDTH-1){1'b0}}};
      cnt_n   = CW'(1);
      state_n = SHIFT;
    end else if (sin_en) begin
      case (state)
        SHIFT: begin
          shreg_n = {sin, shreg[WIDTH-1:1]};
          if (bit_cnt == LAST) begin
`ifdef PARITY_EN
            state_n = PARITY;
            cnt_n   = bit_cnt + 1'b1;
`else
            complete = 1'b1;
            state_n  = IDLE;
            cnt_n    = '0;
`endif
          end else begin
            cnt_n = bit_cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          complete = 1'b1;
          word     = shreg;
          perr_w   = ^{shreg, sin};
          state_n  = IDLE;
          cnt_n    = '0;
        end
`endif
        default: ;
      endcase
    end
  end

  // A same-edge consume frees the buffer, so completion never overruns then.
  assign load    = complete && (!out_valid || out_ready);
  assign overrun = complete && out_valid && !out_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovr       <= 1'b0;
`ifdef PARITY_EN
      out_perr  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shreg   <= shreg_n;
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
`ifdef PARITY_EN
        out_perr  <= perr_w;
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_clr) begin
        ovr <= 1'b0;
      end else if (overrun) begin
        ovr <= 1'b1;
      end
    end
  end

endmodule
